instruction_fetch_unit: RTL and testbench



---
 rtl/instruction_fetch_unit.sv | 138 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// Module  : instruction_fetch_unit
// Brief   : MIPS fetch stage. Owns the PC, reads the instruction memory and
//           loads the IF/ID pipeline register.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 128
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic [31:0] InstrAddress,
  input  logic [31:0] InstrIn,
  output logic [31:0] PC,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic        AddrFault,
  output logic [31:0] FetchCount
);

  localparam logic [31:0] C_MEM_WORDS = 32'(MEM_WORDS);

  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_FAULT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_word_idx;
  logic        w_idx_oob;
  logic        w_tgt_misaligned;

  assign w_pc_plus4       = pc_q + 32'd4;
  assign w_word_idx       = {2'b00, pc_q[31:2]};
  assign w_idx_oob        = (w_word_idx >= C_MEM_WORDS);
  assign w_tgt_misaligned = (RedirectTarget[1:0] != 2'b00);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      pcp4_q  <= 32'd0;
      valid_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Priority inside RUN: address fault, then redirect, then stall, then advance.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    count_d = count_q;

    case (state_q)
      S_RUN: begin
        if (w_idx_oob || (Redirect && w_tgt_misaligned)) begin
          state_d = S_FAULT;
          instr_d = 32'd0;
          pcp4_d  = 32'd0;
          valid_d = 1'b0;
        end else if (Redirect) begin
          pc_d    = RedirectTarget;
          instr_d = 32'd0;
          pcp4_d  = 32'd0;
          valid_d = 1'b0;
        end else if (Stall) begin
          if (Flush) begin
            instr_d = 32'd0;
            pcp4_d  = 32'd0;
            valid_d = 1'b0;
          end
        end else begin
          pc_d = w_pc_plus4;
          if (Flush) begin
            instr_d = 32'd0;
            pcp4_d  = 32'd0;
            valid_d = 1'b0;
          end else begin
            instr_d = InstrIn;
            pcp4_d  = w_pc_plus4;
            valid_d = 1'b1;
            count_d = count_q + 32'd1;
          end
        end
      end

      S_FAULT: begin
        instr_d = 32'd0;
        pcp4_d  = 32'd0;
        valid_d = 1'b0;
      end

      default: begin
        state_d = S_FAULT;
        instr_d = 32'd0;
        pcp4_d  = 32'd0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign InstrAddress      = pc_q;
  assign PC                = pc_q;
  assign IF_ID_Instruction = instr_q;
  assign IF_ID_PCPlus4     = pcp4_q;
  assign IF_ID_Valid       = valid_q;
  assign AddrFault         = (state_q == S_FAULT);
  assign FetchCount        = count_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// ============================================================================
// Module  : tb_instruction_fetch_unit
// Brief   : Directed and randomized bench for instruction_fetch_unit with a
//           cycle-level behavioural model of the fetch stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_unit;

  localparam int          MW    = 4;
  localparam logic [31:0] RSTPC = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Stall;
  logic        Flush;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic [31:0] InstrAddress;
  logic [31:0] InstrIn;
  logic [31:0] PC;
  logic [31:0] IF_ID_Instruction;
  logic [31:0] IF_ID_PCPlus4;
  logic        IF_ID_Valid;
  logic        AddrFault;
  logic [31:0] FetchCount;

  instruction_fetch_unit #(
    .RESET_PC (RSTPC),
    .MEM_WORDS(MW)
  ) dut (
    .Clk              (Clk),
    .Rst              (Rst),
    .Stall            (Stall),
    .Flush            (Flush),
    .Redirect         (Redirect),
    .RedirectTarget   (RedirectTarget),
    .InstrAddress     (InstrAddress),
    .InstrIn          (InstrIn),
    .PC               (PC),
    .IF_ID_Instruction(IF_ID_Instruction),
    .IF_ID_PCPlus4    (IF_ID_PCPlus4),
    .IF_ID_Valid      (IF_ID_Valid),
    .AddrFault        (AddrFault),
    .FetchCount       (FetchCount)
  );

  always #5 Clk = ~Clk;

  // Instruction memory: combinational read of word PC[31:2].
  logic [31:0] mem [0:63];
  assign InstrIn = mem[InstrAddress[7:2]];

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the architectural state.
  logic [31:0] m_pc, m_instr, m_pcp4, m_cnt;
  logic        m_valid, m_fault;

  always @(posedge Clk) begin
    logic bubble;
    bubble = 1'b0;
    if (Rst) begin
      m_pc = RSTPC; m_instr = 0; m_pcp4 = 0; m_valid = 0; m_fault = 0; m_cnt = 0;
    end else if (m_fault) begin
      bubble = 1'b1;
    end else if ((m_pc / 4) >= MW || (Redirect && (RedirectTarget % 4) != 0)) begin
      m_fault = 1'b1;
      bubble  = 1'b1;
    end else if (Redirect) begin
      m_pc   = RedirectTarget;
      bubble = 1'b1;
    end else if (Stall) begin
      bubble = Flush;
    end else begin
      if (Flush) begin
        bubble = 1'b1;
      end else begin
        m_instr = mem[m_pc[7:2]];
        m_pcp4  = m_pc + 4;
        m_valid = 1'b1;
        m_cnt   = m_cnt + 1;
      end
      m_pc = m_pc + 4;
    end
    if (bubble) begin
      m_instr = 0; m_pcp4 = 0; m_valid = 0;
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("pc",        PC,                     m_pc);
      chk("iaddr",     InstrAddress,           m_pc);
      chk("ifid_ins",  IF_ID_Instruction,      m_instr);
      chk("ifid_pcp4", IF_ID_PCPlus4,          m_pcp4);
      chk("ifid_vld",  {31'd0, IF_ID_Valid},   {31'd0, m_valid});
      chk("fault",     {31'd0, AddrFault},     {31'd0, m_fault});
      chk("fcount",    FetchCount,             m_cnt);
    end
  end

  task automatic drive(input logic r, input logic s, input logic f,
                       input logic rd, input logic [31:0] tgt);
    Rst = r; Stall = s; Flush = f; Redirect = rd; RedirectTarget = tgt;
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h2008_0002;
    mem[1] = 32'h2009_0003;
    mem[2] = 32'h200A_0004;
    mem[3] = 32'h0109_5020;

    drive(1, 0, 0, 0, 0);
    tick();
    chk_en = 1'b1;
    chk("rst_pc",    PC, 32'h0);
    chk("rst_vld",   {31'd0, IF_ID_Valid}, 32'd0);
    chk("rst_ins",   IF_ID_Instruction, 32'h0);
    chk("rst_fault", {31'd0, AddrFault}, 32'd0);
    chk("rst_cnt",   FetchCount, 32'd0);

    // Sequential fetch.
    drive(0, 0, 0, 0, 0);
    tick(); chk("seq1_ins", IF_ID_Instruction, 32'h2008_0002); chk("seq1_p4", IF_ID_PCPlus4, 32'd4);
    tick(); chk("seq2_ins", IF_ID_Instruction, 32'h2009_0003); chk("seq2_p4", IF_ID_PCPlus4, 32'd8);
    chk("seq2_pc", PC, 32'd8);

    // Stall two cycles while PC=8.
    drive(0, 1, 0, 0, 0);
    tick(); tick();
    chk("stall_pc", PC, 32'd8);
    chk("stall_ins", IF_ID_Instruction, 32'h2009_0003);
    chk("stall_cnt", FetchCount, 32'd2);
    drive(0, 0, 0, 0, 0);
    tick();
    chk("seq3_ins", IF_ID_Instruction, 32'h200A_0004);
    chk("seq3_p4", IF_ID_PCPlus4, 32'd12);
    chk("seq3_cnt", FetchCount, 32'd3);
    chk("seq3_pc", PC, 32'd12);

    // Redirect to 4: one bubble then the target instruction.
    drive(0, 0, 0, 1, 32'h4);
    tick();
    chk("rd_vld", {31'd0, IF_ID_Valid}, 32'd0);
    chk("rd_ins", IF_ID_Instruction, 32'h0);
    chk("rd_pc", PC, 32'd4);
    drive(0, 0, 0, 0, 0);
    tick();
    chk("rd_tgt_ins", IF_ID_Instruction, 32'h2009_0003);
    chk("rd_tgt_p4", IF_ID_PCPlus4, 32'd8);

    // Stall+Redirect, then Stall+Flush.
    drive(0, 1, 0, 1, 32'h0);
    tick();
    chk("sr_pc", PC, 32'h0);
    chk("sr_vld", {31'd0, IF_ID_Valid}, 32'd0);
    drive(0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 1, 0, 0);
    tick();
    chk("sf_pc", PC, 32'd4);
    chk("sf_vld", {31'd0, IF_ID_Valid}, 32'd0);

    // Out-of-range fetch with MEM_WORDS=4.
    drive(1, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    tick(); tick(); tick(); tick();
    chk("oob_pc", PC, 32'd16);
    chk("oob_pre_fault", {31'd0, AddrFault}, 32'd0);
    tick();
    chk("oob_fault", {31'd0, AddrFault}, 32'd1);
    chk("oob_vld", {31'd0, IF_ID_Valid}, 32'd0);
    drive(0, 0, 0, 1, 32'h0);
    tick();
    chk("flt_rd_pc", PC, 32'd16);
    chk("flt_cnt", FetchCount, 32'd4);

    // Reset from FAULT, then restart.
    drive(1, 0, 0, 0, 0);
    tick();
    chk("rflt_fault", {31'd0, AddrFault}, 32'd0);
    chk("rflt_pc", PC, 32'd0);
    chk("rflt_cnt", FetchCount, 32'd0);
    drive(0, 0, 0, 0, 0);
    tick();
    chk("rflt_ins", IF_ID_Instruction, 32'h2008_0002);

    // Misaligned redirect target.
    drive(0, 0, 0, 1, 32'h6);
    tick();
    chk("mis_fault", {31'd0, AddrFault}, 32'd1);
    chk("mis_pc", PC, 32'd4);

    // Reset while stalled.
    drive(1, 1, 0, 0, 0);
    tick();
    chk("rstall_pc", PC, 32'd0);
    chk("rstall_vld", {31'd0, IF_ID_Valid}, 32'd0);
    chk("rstall_fault", {31'd0, AddrFault}, 32'd0);
    drive(0, 0, 0, 0, 0);
    tick();
    chk("rstall_ins", IF_ID_Instruction, 32'h2008_0002);

    // Randomized traffic checked every cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] tgt;
      tgt = {26'd0, 4'($urandom_range(0, 5)), 2'b00};
      if ($urandom_range(0, 7) == 0) tgt[1:0] = 2'($urandom);
      drive(($urandom_range(0, 29) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 5) == 0),
            tgt);
      tick();
    end

    @(negedge Clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
